dm_sched: RTL and testbench
===========================

Name: dm_sched

Overview:
- Sequencer for one PE's dual-read/single-write data memory.
- Runs two phases: a LOAD phase that streams operands into the memory, and an EXEC phase that issues instructions and generates the matching write-back enables.
- Sits between the PE-array control/instruction fetch and the data memory. Drives that memory's wren, rden, wben, inst_v and inst inputs.
- Enforces single-write-port ownership and optionally stalls on read-after-write hazards.

Parameters:
- INST_WIDTH, 32, instruction width. Fields: [7:0] raddr0, [15:8] raddr1, [23:16] wb_addr, [INST_WIDTH-1] wb flag.
- DM_ADDR_WIDTH, 8, data-memory address width.
- WB_LAT, 4, cycles from instruction issue (dm_inst_v) to its write-back (dm_wben). Legal range 2..8.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_load  in  1  one-cycle pulse; begins LOAD phase.
- load_len  in  DM_ADDR_WIDTH+1  number of words to load; sampled with start_load.
- din_v  in  1  load data beat valid.
- din_rdy  out  1  load beat accepted when din_v & din_rdy.
- start_exec  in  1  one-cycle pulse; begins EXEC phase.
- inst_in_v  in  1  instruction valid.
- inst_in  in  INST_WIDTH  instruction.
- inst_in_last  in  1  marks the final instruction of the program.
- inst_in_rdy  out  1  instruction accepted when inst_in_v & inst_in_rdy.
- dm_wren  out  1  load-write enable to data memory.
- dm_rden  out  1  read enable to data memory.
- dm_wben  out  1  write-back enable to data memory.
- dm_inst_v  out  1  instruction valid to data memory.
- dm_inst  out  INST_WIDTH  instruction to data memory.
- busy  out  1  high in any state other than IDLE.
- load_done  out  1  one-cycle pulse when LOAD completes.
- exec_done  out  1  one-cycle pulse when DRAIN completes.

Behaviour:
- Reset (rst=0), effective immediately and asynchronously:
  - state=IDLE; all outputs 0; load counter 0; in-flight shift register cleared.
  - Reset mid-phase aborts the phase; no done pulse is generated.
- States: IDLE, LOAD, EXEC, DRAIN.
- IDLE:
  - start_load moves to LOAD. If load_len==0, stay in IDLE and pulse load_done the next cycle.
  - start_exec moves to EXEC.
  - If start_load and start_exec are high together, LOAD wins and start_exec is dropped.
  - Start pulses outside IDLE are ignored.
- LOAD:
  - din_rdy=1.
  - Each accepted beat registers dm_wren=1 for exactly one cycle, one cycle after acceptance, and increments the counter.
  - When the accepted count reaches load_len: go to IDLE, pulse load_done, din_rdy=0 in the same cycle as load_done.
  - dm_rden, dm_wben and dm_inst_v stay 0 throughout LOAD.
- EXEC:
  - Each accepted instruction produces registered dm_inst_v=1 and dm_inst=inst_in in cycle T+1.
  - It then produces dm_rden=1 in cycle T+2. This covers the memory's one-cycle address-register latency.
- Write-back tracking:
  - An in-flight shift register of depth WB_LAT holds {valid, wb_addr} per issued instruction that has wb flag=1.
  - dm_wben=1 exactly WB_LAT cycles after that instruction's dm_inst_v.
  - Instructions with wb flag=0 issue normally but generate no dm_wben.
- inst_in_rdy = (state==EXEC) & ~hazard (see Optional Feature).
- When the instruction with inst_in_last is accepted, go to DRAIN.
- DRAIN:
  - inst_in_rdy=0.
  - When all in-flight entries are invalid and the final dm_wben has fired, go to IDLE and pulse exec_done.
  - With no write-backs outstanding, exec_done fires the cycle after entering DRAIN.
- dm_wren and dm_wben are never high in the same cycle; the state machine guarantees this.
- Throughput is one instruction per cycle when there is no stall.
- load_len up to 2**DM_ADDR_WIDTH is legal. The counter is DM_ADDR_WIDTH+1 bits wide with no wrap inside the phase.

Optional Feature:
- Macro: DM_RAW_STALL_EN.
- Defined:
  - hazard=1 when inst_in_v and inst_in[7:0] or inst_in[15:8] equals the wb_addr of any valid in-flight entry, including the instruction issuing this cycle.
  - inst_in_rdy is held low until the matching entry retires, i.e. the cycle after its dm_wben.
- Not defined: hazard=0. Instructions issue back-to-back and software guarantees RAW spacing.

Test Plan:
- start_load, load_len=4, din_v held high: dm_wren high for 4 consecutive cycles starting 1 cycle after the first accept; load_done one cycle after the 4th accept; busy returns to 0.
- start_load with load_len=0: load_done the next cycle; no dm_wren.
- start_exec, 3 instructions with wb flag=1 back-to-back, last flagged inst_in_last, no address overlap: dm_inst_v cycles T+1..T+3; dm_rden cycles T+2..T+4; dm_wben cycles T+1+WB_LAT .. T+3+WB_LAT; exec_done one cycle after the last dm_wben.
- DM_RAW_STALL_EN defined: instruction A with wb_addr=0x10, then B with raddr0=0x10: inst_in_rdy is low until the cycle after A's dm_wben, then B issues. Undefined: B issues in the cycle right after A.
- Simultaneous start_load and start_exec: LOAD entered; no dm_inst_v until a later start_exec.
- rst asserted during EXEC with 2 write-backs in flight: all outputs 0 immediately; no dm_wben or exec_done after reset release.

Source files
------------

// File: rtl/dm_sched.sv
// Data-memory sequencer for one PE: LOAD streams operands in, EXEC issues instructions and
// times their write-backs. Define DM_RAW_STALL_EN to stall issue on read-after-write hazards.
module dm_sched #(
  parameter int unsigned INST_WIDTH    = 32,
  parameter int unsigned DM_ADDR_WIDTH = 8,
  parameter int unsigned WB_LAT        = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_load_i,
  input  logic [DM_ADDR_WIDTH:0]  load_len_i,
  input  logic                    din_v_i,
  output logic                    din_rdy_o,
  input  logic                    start_exec_i,
  input  logic                    inst_in_v_i,
  input  logic [INST_WIDTH-1:0]   inst_in_i,
  input  logic                    inst_in_last_i,
  output logic                    inst_in_rdy_o,
  output logic                    dm_wren_o,
  output logic                    dm_rden_o,
  output logic                    dm_wben_o,
  output logic                    dm_inst_v_o,
  output logic [INST_WIDTH-1:0]   dm_inst_o,
  output logic                    busy_o,
  output logic                    load_done_o,
  output logic                    exec_done_o
);

  typedef enum logic [1:0] {StIdle, StLoad, StExec, StDrain} state_e;

  state_e                  state_q, state_d;
  logic [DM_ADDR_WIDTH:0]  cnt_q, cnt_d;
  logic [DM_ADDR_WIDTH:0]  len_q, len_d;
  logic                    wren_q, wren_d;
  logic                    rden_q, rden_d;
  logic                    inst_v_q, inst_v_d;
  logic [INST_WIDTH-1:0]   inst_q, inst_d;
  logic                    load_done_q, load_done_d;
  logic                    exec_done_q, exec_done_d;
  // Stage k holds an entry k+1 cycles after acceptance; the top stage is the write-back cycle.
  logic [WB_LAT:0]         wb_v_q, wb_v_d;

  logic din_acc, inst_acc, inflight, hazard;

  assign din_acc  = din_v_i & (state_q == StLoad);
  assign inst_acc = inst_in_v_i & inst_in_rdy_o;
  assign inflight = |wb_v_q[WB_LAT-1:0];
  assign wb_v_d   = {wb_v_q[WB_LAT-1:0], inst_acc & inst_in_i[INST_WIDTH-1]};

`ifdef DM_RAW_STALL_EN
  localparam int unsigned FieldW = 8;
  logic [WB_LAT:0][FieldW-1:0] wb_addr_q, wb_addr_d;

  assign wb_addr_d = {wb_addr_q[WB_LAT-1:0], inst_in_i[23:16]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_addr_q <= '0;
    end else begin
      wb_addr_q <= wb_addr_d;
    end
  end

  // Entries stay visible through their write-back cycle, so issue resumes the cycle after.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i <= WB_LAT; i++) begin
      if (wb_v_q[i] && ((inst_in_i[7:0] == wb_addr_q[i]) || (inst_in_i[15:8] == wb_addr_q[i]))) begin
        hazard = 1'b1;
      end
    end
    hazard = hazard & inst_in_v_i;
  end
`else
  assign hazard = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    load_done_d = 1'b0;
    exec_done_d = 1'b0;
    wren_d      = din_acc;
    inst_v_d    = inst_acc;
    inst_d      = inst_acc ? inst_in_i : inst_q;
    rden_d      = inst_v_q;
    case (state_q)
      StIdle: begin
        if (start_load_i) begin
          if (load_len_i == '0) begin
            load_done_d = 1'b1;
          end else begin
            state_d = StLoad;
            cnt_d   = '0;
            len_d   = load_len_i;
          end
        end else if (start_exec_i) begin
          state_d = StExec;
        end
      end
      StLoad: begin
        if (din_acc) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == len_q) begin
            state_d     = StIdle;
            load_done_d = 1'b1;
          end
        end
      end
      StExec: begin
        if (inst_acc && inst_in_last_i) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Leaving while the final write-back is on the output stage puts done right after it.
        if (!inflight) begin
          state_d     = StIdle;
          exec_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      len_q       <= '0;
      wren_q      <= 1'b0;
      rden_q      <= 1'b0;
      inst_v_q    <= 1'b0;
      inst_q      <= '0;
      load_done_q <= 1'b0;
      exec_done_q <= 1'b0;
      wb_v_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      wren_q      <= wren_d;
      rden_q      <= rden_d;
      inst_v_q    <= inst_v_d;
      inst_q      <= inst_d;
      load_done_q <= load_done_d;
      exec_done_q <= exec_done_d;
      wb_v_q      <= wb_v_d;
    end
  end

  assign din_rdy_o     = (state_q == StLoad);
  assign inst_in_rdy_o = (state_q == StExec) & ~hazard;
  assign dm_wren_o     = wren_q;
  assign dm_rden_o     = rden_q;
  assign dm_wben_o     = wb_v_q[WB_LAT];
  assign dm_inst_v_o   = inst_v_q;
  assign dm_inst_o     = inst_q;
  assign busy_o        = (state_q != StIdle);
  assign load_done_o   = load_done_q;
  assign exec_done_o   = exec_done_q;

endmodule

// File: tb/tb_dm_sched.sv
// Scoreboard bench for dm_sched: stimulus pushes expected event cycles, a negedge monitor
// pops and compares every output pulse.
module tb_dm_sched;
  localparam int unsigned IW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned WB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start_load = 1'b0, start_exec = 1'b0;
  logic [AW:0]   load_len = '0;
  logic          din_v = 1'b0, din_rdy;
  logic          inst_in_v = 1'b0, inst_in_last = 1'b0, inst_in_rdy;
  logic [IW-1:0] inst_in = '0;
  logic          dm_wren, dm_rden, dm_wben, dm_inst_v, busy, load_done, exec_done;
  logic [IW-1:0] dm_inst;

  dm_sched #(.INST_WIDTH(IW), .DM_ADDR_WIDTH(AW), .WB_LAT(WB)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_load_i(start_load), .load_len_i(load_len),
    .din_v_i(din_v), .din_rdy_o(din_rdy), .start_exec_i(start_exec),
    .inst_in_v_i(inst_in_v), .inst_in_i(inst_in), .inst_in_last_i(inst_in_last),
    .inst_in_rdy_o(inst_in_rdy), .dm_wren_o(dm_wren), .dm_rden_o(dm_rden),
    .dm_wben_o(dm_wben), .dm_inst_v_o(dm_inst_v), .dm_inst_o(dm_inst), .busy_o(busy),
    .load_done_o(load_done), .exec_done_o(exec_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int q_wren[$], q_rden[$], q_wben[$], q_iv[$], q_ld[$], q_ed[$];
  logic [IW-1:0] q_inst[$];

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic checkw(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected events for an instruction accepted in cycle t.
  task automatic issue(input logic [IW-1:0] ins, input int t);
    q_iv.push_back(t + 1);
    q_inst.push_back(ins);
    q_rden.push_back(t + 2);
    if (ins[IW-1]) q_wben.push_back(t + 1 + WB);
  endtask

  // Monitor: every pulse must match the head of its queue, and every due entry must fire.
  always @(negedge clk) begin
    logic e;
    logic [IW-1:0] ei;
    if (rst_n) begin
      e = (q_wren.size() > 0 && q_wren[0] == cyc);
      if (e) void'(q_wren.pop_front());
      if (dm_wren || e) check1("dm_wren", dm_wren, e);
      e = (q_rden.size() > 0 && q_rden[0] == cyc);
      if (e) void'(q_rden.pop_front());
      if (dm_rden || e) check1("dm_rden", dm_rden, e);
      e = (q_wben.size() > 0 && q_wben[0] == cyc);
      if (e) void'(q_wben.pop_front());
      if (dm_wben || e) check1("dm_wben", dm_wben, e);
      e = (q_ld.size() > 0 && q_ld[0] == cyc);
      if (e) void'(q_ld.pop_front());
      if (load_done || e) check1("load_done", load_done, e);
      e = (q_ed.size() > 0 && q_ed[0] == cyc);
      if (e) void'(q_ed.pop_front());
      if (exec_done || e) check1("exec_done", exec_done, e);
      e  = (q_iv.size() > 0 && q_iv[0] == cyc);
      ei = '0;
      if (e) begin
        void'(q_iv.pop_front());
        ei = q_inst.pop_front();
      end
      if (dm_inst_v || e) check1("dm_inst_v", dm_inst_v, e);
      if (dm_inst_v && e) checkw("dm_inst", dm_inst, ei);
    end
  end

  logic [IW-1:0] prog[3];
  logic [IW-1:0] ins_a, ins_b, ins_nwb;
  int t;

  initial begin
    prog[0] = {1'b1, 7'h00, 8'h20, 8'h01, 8'h02};
    prog[1] = {1'b1, 7'h00, 8'h21, 8'h03, 8'h04};
    prog[2] = {1'b1, 7'h00, 8'h22, 8'h05, 8'h06};
    ins_a   = {1'b1, 7'h00, 8'h10, 8'h01, 8'h02};
    ins_b   = {1'b0, 7'h00, 8'h33, 8'h05, 8'h10};
    ins_nwb = {1'b0, 7'h00, 8'h44, 8'h07, 8'h08};

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    checkw("reset_outs", {23'b0, din_rdy, inst_in_rdy, dm_wren, dm_rden, dm_wben, dm_inst_v,
                          busy, load_done, exec_done}, '0);
    checkw("reset_inst", dm_inst, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // LOAD of 4 words with din_v held high
    t = cyc;
    start_load = 1'b1;
    load_len   = 4;
    for (int i = 2; i <= 5; i++) q_wren.push_back(t + i);
    q_ld.push_back(t + 5);
    tick();
    start_load = 1'b0;
    din_v      = 1'b1;
    check1("load_din_rdy", din_rdy, 1'b1);
    check1("load_busy", busy, 1'b1);
    repeat (4) tick();
    din_v = 1'b0;
    check1("load_end_rdy", din_rdy, 1'b0);
    check1("load_end_busy", busy, 1'b0);
    repeat (2) tick();

    // Zero-length LOAD
    t = cyc;
    start_load = 1'b1;
    load_len   = 0;
    q_ld.push_back(t + 1);
    tick();
    start_load = 1'b0;
    check1("len0_busy", busy, 1'b0);
    repeat (3) tick();

    // EXEC: three back-to-back write-back instructions
    start_exec = 1'b1;
    tick();
    start_exec = 1'b0;
    t = cyc;
    check1("exec_busy", busy, 1'b1);
    inst_in_v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inst_in      = prog[i];
      inst_in_last = (i == 2);
      check1("exec_rdy", inst_in_rdy, 1'b1);
      issue(prog[i], t + i);
      tick();
    end
    inst_in_v    = 1'b0;
    inst_in_last = 1'b0;
    q_ed.push_back(t + 4 + WB);
    check1("drain_rdy", inst_in_rdy, 1'b0);
    repeat (WB + 4) tick();
    check1("exec_end_busy", busy, 1'b0);

    // EXEC: single instruction without write-back
    start_exec = 1'b1;
    tick();
    start_exec   = 1'b0;
    t            = cyc;
    inst_in_v    = 1'b1;
    inst_in      = ins_nwb;
    inst_in_last = 1'b1;
    issue(ins_nwb, t);
    q_ed.push_back(t + 2);
    tick();
    inst_in_v    = 1'b0;
    inst_in_last = 1'b0;
    repeat (3) tick();
    check1("nwb_end_busy", busy, 1'b0);

    // RAW pair: A writes 0x10, B reads 0x10
    start_exec = 1'b1;
    tick();
    start_exec = 1'b0;
    t          = cyc;
    inst_in_v  = 1'b1;
    inst_in    = ins_a;
    issue(ins_a, t);
    tick();
    inst_in      = ins_b;
    inst_in_last = 1'b1;
`ifdef DM_RAW_STALL_EN
    check1("raw_stall_rdy", inst_in_rdy, 1'b0);
    repeat (WB) tick();
    check1("raw_stall_wb_cycle_rdy", inst_in_rdy, 1'b0);
    tick();
    check1("raw_release_rdy", inst_in_rdy, 1'b1);
    issue(ins_b, t + 2 + WB);
    q_ed.push_back(t + 4 + WB);
    tick();
`else
    check1("raw_nostall_rdy", inst_in_rdy, 1'b1);
    issue(ins_b, t + 1);
    q_ed.push_back(t + 2 + WB);
    tick();
`endif
    inst_in_v    = 1'b0;
    inst_in_last = 1'b0;
    repeat (WB + 4) tick();
    check1("raw_end_busy", busy, 1'b0);

    // Simultaneous starts: LOAD wins, start_exec inside LOAD ignored
    t = cyc;
    start_load = 1'b1;
    start_exec = 1'b1;
    load_len   = 2;
    q_wren.push_back(t + 2);
    q_wren.push_back(t + 3);
    q_ld.push_back(t + 3);
    tick();
    start_load = 1'b0;
    start_exec = 1'b0;
    din_v      = 1'b1;
    inst_in_v  = 1'b1;
    inst_in    = prog[0];
    check1("sim_inst_rdy", inst_in_rdy, 1'b0);
    check1("sim_din_rdy", din_rdy, 1'b1);
    tick();
    start_exec = 1'b1;
    tick();
    start_exec = 1'b0;
    din_v      = 1'b0;
    inst_in_v  = 1'b0;
    check1("sim_end_busy", busy, 1'b0);
    tick();
    check1("sim_ignored_exec", busy, 1'b0);
    repeat (2) tick();

    // Reset during EXEC with two write-backs in flight
    start_exec = 1'b1;
    tick();
    start_exec = 1'b0;
    t          = cyc;
    inst_in_v  = 1'b1;
    inst_in    = {1'b1, 7'h00, 8'h40, 8'h01, 8'h02};
    q_iv.push_back(t + 1);
    q_inst.push_back(inst_in);
    tick();
    inst_in = {1'b1, 7'h00, 8'h41, 8'h03, 8'h04};
    tick();
    inst_in_v = 1'b0;
    rst_n     = 1'b0;
    #1;
    checkw("midrst_outs", {23'b0, din_rdy, inst_in_rdy, dm_wren, dm_rden, dm_wben, dm_inst_v,
                           busy, load_done, exec_done}, '0);
    checkw("midrst_inst", dm_inst, '0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (WB + 4) tick();
    check1("postrst_busy", busy, 1'b0);

    checkw("pending_expect", q_wren.size() + q_rden.size() + q_wben.size() + q_iv.size() +
                             q_ld.size() + q_ed.size(), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
